// File: rtl/warp_ahb_arbiter_pkg.sv
// ============================================================================
// warp_ahb_arbiter_pkg : shared AHB-Lite encodings for the two-port arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package warp_ahb_arbiter_pkg;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_LSU   = 1'b1
    } port_e;

    localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] AHB_HBURST_SINGLE = 3'b000;
    localparam logic [3:0] AHB_HPROT_FETCH   = 4'b0010;
    localparam logic [3:0] AHB_HPROT_DATA    = 4'b0011;

    localparam logic [2:0] AHB_HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] AHB_HSIZE_HALF  = 3'b001;
    localparam logic [2:0] AHB_HSIZE_WORD  = 3'b010;
    localparam logic [2:0] AHB_HSIZE_DWORD = 3'b011;

endpackage : warp_ahb_arbiter_pkg

`default_nettype wire

// File: rtl/warp_rr_arb2.sv
// ============================================================================
// warp_rr_arb2 : two-way round-robin grant with a lock that freezes the grant
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_rr_arb2
    import warp_ahb_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_lock,
    input  logic       i_accept,
    output logic       o_grant
);

    logic grant_q;
    logic grant_d;
    logic last_grant_q;

    // On a tie or with nobody requesting, the port that did not win last goes next.
    always_comb begin
        grant_d = ~last_grant_q;
        if (i_lock) begin
            grant_d = grant_q;
        end else if (i_valid == 2'b01) begin
            grant_d = PORT_FETCH;
        end else if (i_valid == 2'b10) begin
            grant_d = PORT_LSU;
        end
    end

    assign o_grant = grant_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant_q      <= PORT_FETCH;
            last_grant_q <= PORT_LSU;
        end else begin
            grant_q <= grant_d;
            if (i_accept) begin
                last_grant_q <= grant_d;
            end
        end
    end

endmodule : warp_rr_arb2

`default_nettype wire

// File: rtl/warp_ahb_arbiter.sv
// ============================================================================
// warp_ahb_arbiter : shares one AHB-Lite manager port between fetch and LSU
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_ahb_arbiter
    import warp_ahb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_req_valid,
    output logic [1:0]              o_req_ready,
    input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]              i_req_write,
    input  logic [2*3-1:0]          i_req_size,
    input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
    input  logic [2*STRB_WIDTH-1:0] i_req_wstrb,
    output logic [1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic [ADDR_WIDTH-1:0]   o_ahb_haddr,
    output logic [1:0]              o_ahb_htrans,
    output logic [2:0]              o_ahb_hburst,
    output logic [2:0]              o_ahb_hsize,
    output logic [3:0]              o_ahb_hprot,
    output logic                    o_ahb_hwrite,
    output logic [DATA_WIDTH-1:0]   o_ahb_hwdata,
    output logic [STRB_WIDTH-1:0]   o_ahb_hwstrb,
    output logic                    o_ahb_hmastlock,
    input  logic [DATA_WIDTH-1:0]   i_ahb_hrdata,
    input  logic                    i_ahb_hready,
    input  logic                    i_ahb_hresp
);

    logic [ADDR_WIDTH-1:0] w_addr  [2];
    logic [2:0]            w_size  [2];
    logic [DATA_WIDTH-1:0] w_wdata [2];
    logic [STRB_WIDTH-1:0] w_wstrb [2];

    for (genvar k = 0; k < 2; k++) begin : g_port
        assign w_addr[k]  = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_size[k]  = i_req_size[k*3 +: 3];
        assign w_wdata[k] = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_wstrb[k] = i_req_wstrb[k*STRB_WIDTH +: STRB_WIDTH];
    end

    logic                  w_grant;
    logic                  w_err_first;
    logic                  w_nonseq;
    logic                  w_accept;
    logic                  lock_q;
    logic                  lock_d;
    logic                  dp_valid_q;
    logic                  dp_owner_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [STRB_WIDTH-1:0] hwstrb_q;

    warp_rr_arb2 u_rr_arb2 (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_req_valid),
        .i_lock   (lock_q),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // First cycle of a two-cycle ERROR response: the address phase is suppressed.
    assign w_err_first = i_ahb_hresp & ~i_ahb_hready;
    assign w_nonseq    = ~i_rst & i_req_valid[w_grant] & ~w_err_first;
    assign w_accept    = w_nonseq & i_ahb_hready;

    assign o_ahb_htrans    = w_nonseq ? AHB_HTRANS_NONSEQ : AHB_HTRANS_IDLE;
    assign o_ahb_haddr     = w_addr[w_grant];
    assign o_ahb_hsize     = w_size[w_grant];
    assign o_ahb_hwrite    = i_req_write[w_grant];
    assign o_ahb_hprot     = (w_grant == PORT_LSU) ? AHB_HPROT_DATA : AHB_HPROT_FETCH;
    assign o_ahb_hburst    = AHB_HBURST_SINGLE;
    assign o_ahb_hmastlock = 1'b0;
    assign o_ahb_hwdata    = hwdata_q;
    assign o_ahb_hwstrb    = hwstrb_q;
    assign o_req_ready     = w_accept ? (2'b01 << w_grant) : 2'b00;

    assign o_rsp_valid = (~i_rst & dp_valid_q & i_ahb_hready) ? (2'b01 << dp_owner_q) : 2'b00;
    assign o_rsp_rdata = i_ahb_hrdata;
    assign o_rsp_err   = i_ahb_hresp;

    // A stalled address phase holds the grant until it is taken or an error cancels it.
    always_comb begin
        lock_d = lock_q;
        if (w_accept || w_err_first) begin
            lock_d = 1'b0;
        end else if (w_nonseq && !i_ahb_hready) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_owner_q <= 1'b0;
            hwdata_q   <= '0;
            hwstrb_q   <= '0;
        end else begin
            lock_q <= lock_d;
            if (w_accept) begin
                dp_valid_q <= 1'b1;
                dp_owner_q <= w_grant;
                hwdata_q   <= w_wdata[w_grant];
                hwstrb_q   <= w_wstrb[w_grant];
            end else if (i_ahb_hready) begin
                dp_valid_q <= 1'b0;
            end
        end
    end

endmodule : warp_ahb_arbiter

`default_nettype wire

// File: tb/tb_warp_ahb_arbiter.sv
// ============================================================================
// tb_warp_ahb_arbiter : directed self-checking bench for warp_ahb_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_warp_ahb_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*AW-1:0] req_addr;
    logic [1:0]      req_write;
    logic [5:0]      req_size;
    logic [2*DW-1:0] req_wdata;
    logic [2*SW-1:0] req_wstrb;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   haddr;
    logic [1:0]      htrans;
    logic [2:0]      hburst;
    logic [2:0]      hsize;
    logic [3:0]      hprot;
    logic            hwrite;
    logic [DW-1:0]   hwdata;
    logic [SW-1:0]   hwstrb;
    logic            hmastlock;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic            hresp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    warp_ahb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_addr      (req_addr),
        .i_req_write     (req_write),
        .i_req_size      (req_size),
        .i_req_wdata     (req_wdata),
        .i_req_wstrb     (req_wstrb),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_rdata     (rsp_rdata),
        .o_rsp_err       (rsp_err),
        .o_ahb_haddr     (haddr),
        .o_ahb_htrans    (htrans),
        .o_ahb_hburst    (hburst),
        .o_ahb_hsize     (hsize),
        .o_ahb_hprot     (hprot),
        .o_ahb_hwrite    (hwrite),
        .o_ahb_hwdata    (hwdata),
        .o_ahb_hwstrb    (hwstrb),
        .o_ahb_hmastlock (hmastlock),
        .i_ahb_hrdata    (hrdata),
        .i_ahb_hready    (hready),
        .i_ahb_hresp     (hresp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [63:0] a, input logic w,
                           input logic [2:0] sz, input logic [63:0] d, input logic [7:0] s);
        req_valid[p]           = v;
        req_addr[p*AW +: AW]   = a;
        req_write[p]           = w;
        req_size[p*3 +: 3]     = sz;
        req_wdata[p*DW +: DW]  = d;
        req_wstrb[p*SW +: SW]  = s;
    endtask

    // Move to the next sampling point: inputs change at negedge, outputs settle 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_size = '0;
        req_wdata = '0; req_wstrb = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

        // Reset gating with a request already pending
        step();
        set_req(0, 1'b1, 64'h1000, 1'b0, 3'd3, 64'h0, 8'h00);
        #1;
        chk("rst_htrans", {62'd0, htrans}, 64'd0);
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_rsp", {62'd0, rsp_valid}, 64'd0);
        chk("rst_hwdata", hwdata, 64'd0);
        step();

        // Single read on the fetch port
        rst = 1'b0;
        #1;
        chk("rd_htrans", {62'd0, htrans}, 64'd2);
        chk("rd_haddr", haddr, 64'h1000);
        chk("rd_hprot", {60'd0, hprot}, 64'h2);
        chk("rd_hsize", {61'd0, hsize}, 64'd3);
        chk("rd_hburst", {61'd0, hburst}, 64'd0);
        chk("rd_hmastlock", {63'd0, hmastlock}, 64'd0);
        chk("rd_ready", {62'd0, req_ready}, 64'd1);
        step();
        req_valid = 2'b00; hrdata = 64'hDEAD;
        #1;
        chk("rd_rsp", {62'd0, rsp_valid}, 64'd1);
        chk("rd_rdata", rsp_rdata, 64'hDEAD);
        chk("rd_err", {63'd0, rsp_err}, 64'd0);
        chk("rd_idle", {62'd0, htrans}, 64'd0);

        // Contention: fresh reset so the first tie goes to port 0
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 64'h100, 1'b0, 3'd3, 64'h0, 8'h00);
        set_req(1, 1'b1, 64'h200, 1'b0, 3'd2, 64'h0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) req_valid = 2'b00;
            hrdata = 64'h10 + 64'(i);
            #1;
            if (i < 6) begin
                chk($sformatf("ct_ready%0d", i), {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
                chk($sformatf("ct_haddr%0d", i), haddr, (i % 2 == 0) ? 64'h100 : 64'h200);
            end
            if (i > 0) begin
                chk($sformatf("ct_rsp%0d", i), {62'd0, rsp_valid}, ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
            end else begin
                chk("ct_rsp0", {62'd0, rsp_valid}, 64'd0);
            end
            step();
        end

        // Wait states on an LSU write; fetch asserts valid mid-stall
        set_req(1, 1'b1, 64'h2000, 1'b1, 3'd2, 64'h55, 8'hFF);
        hready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) set_req(0, 1'b1, 64'h3000, 1'b0, 3'd3, 64'h0, 8'h00);
            if (i == 3) hready = 1'b1;
            #1;
            chk($sformatf("ws_haddr%0d", i), haddr, 64'h2000);
            chk($sformatf("ws_htrans%0d", i), {62'd0, htrans}, 64'd2);
            chk($sformatf("ws_ready%0d", i), {62'd0, req_ready}, (i == 3) ? 64'd2 : 64'd0);
            if (i == 0) begin
                chk("ws_hprot", {60'd0, hprot}, 64'h3);
                chk("ws_hwrite", {63'd0, hwrite}, 64'd1);
                chk("ws_hsize", {61'd0, hsize}, 64'd2);
                chk("ws_rsp", {62'd0, rsp_valid}, 64'd0);
            end
            step();
        end
        req_valid = 2'b00;
        #1;
        chk("ws_hwdata", hwdata, 64'h55);
        chk("ws_hwstrb", {56'd0, hwstrb}, 64'hFF);
        chk("ws_rsp_done", {62'd0, rsp_valid}, 64'd2);

        // ERROR on an LSU read while fetch is pending
        step();
        set_req(1, 1'b1, 64'h4000, 1'b0, 3'd3, 64'h0, 8'h00);
        #1;
        chk("er_ready0", {62'd0, req_ready}, 64'd2);
        step();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 64'h5000, 1'b0, 3'd3, 64'h0, 8'h00);
        hresp = 1'b1; hready = 1'b0;
        #1;
        chk("er_idle", {62'd0, htrans}, 64'd0);
        chk("er_ready1", {62'd0, req_ready}, 64'd0);
        chk("er_rsp1", {62'd0, rsp_valid}, 64'd0);
        step();
        hready = 1'b1;
        #1;
        chk("er_rsp2", {62'd0, rsp_valid}, 64'd2);
        chk("er_err2", {63'd0, rsp_err}, 64'd1);
        chk("er_ready2", {62'd0, req_ready}, 64'd1);
        chk("er_haddr2", haddr, 64'h5000);
        step();
        req_valid = 2'b00; hresp = 1'b0; hrdata = 64'h77;
        #1;
        chk("er_rsp3", {62'd0, rsp_valid}, 64'd1);
        chk("er_err3", {63'd0, rsp_err}, 64'd0);
        chk("er_rdata3", rsp_rdata, 64'h77);

        // Reset during a data phase; fetch won last, so only reset makes port 0 win the tie
        step();
        set_req(0, 1'b1, 64'h6000, 1'b0, 3'd3, 64'h0, 8'h00);
        #1;
        chk("rm_ready0", {62'd0, req_ready}, 64'd1);
        step();
        rst = 1'b1;
        set_req(1, 1'b1, 64'h7000, 1'b0, 3'd3, 64'h0, 8'h00);
        #1;
        chk("rm_rsp", {62'd0, rsp_valid}, 64'd0);
        chk("rm_idle", {62'd0, htrans}, 64'd0);
        chk("rm_ready1", {62'd0, req_ready}, 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rm_tie", {62'd0, req_ready}, 64'd1);
        chk("rm_rsp_drop", {62'd0, rsp_valid}, 64'd0);
        step();
        req_valid = 2'b00;
        #1;
        chk("rm_rsp_after", {62'd0, rsp_valid}, 64'd1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_warp_ahb_arbiter

`default_nettype wire
